// File: rtl/udp_tx_pkg.sv
// ---------------------------------------------------------------------------
// udp_tx_pkg : shared types, FSM encoding and round-robin pick.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package udp_tx_pkg;

  localparam int LEN_W   = 16;
  localparam int NUM_SRC = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef logic [LEN_W-1:0]   len_t;
  typedef logic [NUM_SRC-1:0] src_vec_t;

  // With both requesting, source 0 wins only when source 1 was served last.
  function automatic src_vec_t rr_pick(input src_vec_t req, input logic last_is_1);
    rr_pick = '0;
    if (req[0] && (!req[1] || last_is_1)) begin
      rr_pick = 2'b01;
    end else if (req[1]) begin
      rr_pick = 2'b10;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/udp_rr_arb2.sv
// ---------------------------------------------------------------------------
// udp_rr_arb2 : two-requester round-robin pick with last-served pointer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module udp_rr_arb2
  import udp_tx_pkg::*;
(
  input  logic                clk_125m,
  input  logic                udp_gmii_rst_n,
  input  logic [NUM_SRC-1:0]  req_i,
  input  logic                update_i,
  output logic [NUM_SRC-1:0]  pick_o
);

  logic last_q;
  logic last_d;

  assign pick_o = rr_pick(req_i, last_q);

  always_comb begin
    last_d = last_q;
    if (update_i && (pick_o != '0)) begin
      last_d = pick_o[1];
    end
  end

  // Pointer starts at source 1 so that source 0 is served first.
  always_ff @(posedge clk_125m or negedge udp_gmii_rst_n) begin
    if (!udp_gmii_rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/udp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// udp_tx_scheduler : shares one UDP/GMII tx engine between two sources. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module udp_tx_scheduler
  import udp_tx_pkg::*;
#(
  parameter int GAP_CYCLES     = 125,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk_125m,
  input  logic               udp_gmii_rst_n,
  input  logic [1:0]         src_req,
  input  logic [LEN_W-1:0]   src_len0,
  input  logic [LEN_W-1:0]   src_len1,
  output logic [1:0]         src_done,
  output logic [1:0]         src_err,
  output logic [1:0]         src_payload_req,
  input  logic [7:0]         src_dat0,
  input  logic [7:0]         src_dat1,
  output logic               tx_en_pulse,
  output logic [LEN_W-1:0]   data_len,
  input  logic               payload_req_i,
  output logic [7:0]         payload_dat_o,
  input  logic               tx_done,
  output logic               busy,
  output logic [1:0]         grant
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tx_en_q, tx_en_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic [15:0]      wd_q, wd_d;
  logic [15:0]      gap_q, gap_d;

  logic [1:0]       pick;
  logic [LEN_W-1:0] pick_len;
  logic             arb_update;

  udp_rr_arb2 u_arb (
    .clk_125m       (clk_125m),
    .udp_gmii_rst_n (udp_gmii_rst_n),
    .req_i          (src_req),
    .update_i       (arb_update),
    .pick_o         (pick)
  );

  assign pick_len = pick[0] ? src_len0 : src_len1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    len_d      = len_q;
    tx_en_d    = 1'b0;
    done_d     = 2'b00;
    err_d      = 2'b00;
    wd_d       = wd_q;
    gap_d      = gap_q;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          arb_update = 1'b1;
          if (pick_len == '0) begin
            // Empty frame is never launched; report it as a rejected request.
            done_d  = pick;
            err_d   = pick;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            len_d   = pick_len;
            grant_d = pick;
            tx_en_d = 1'b1;
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        // Completion takes priority over a coincident watchdog expiry.
        if (tx_done) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (wd_q >= TO_LAST) begin
          done_d  = grant_q;
          err_d   = grant_q;
          grant_d = 2'b00;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_125m or negedge udp_gmii_rst_n) begin
    if (!udp_gmii_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      len_q   <= '0;
      tx_en_q <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      tx_en_q <= tx_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  assign tx_en_pulse     = tx_en_q;
  assign data_len        = len_q;
  assign src_done        = done_q;
  assign src_err         = err_q;
  assign grant           = grant_q;
  assign busy            = (state_q != ST_IDLE);
  assign src_payload_req = {2{payload_req_i}} & grant_q;
  assign payload_dat_o   = grant_q[0] ? src_dat0 :
                           grant_q[1] ? src_dat1 : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_udp_tx_scheduler : directed self-checking bench for udp_tx_scheduler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_udp_tx_scheduler;

  localparam int GAP = 4;
  localparam int TO  = 100;

  logic        clk_125m = 1'b0;
  logic        udp_gmii_rst_n = 1'b0;
  logic [1:0]  src_req = 2'b00;
  logic [15:0] src_len0 = 16'd0;
  logic [15:0] src_len1 = 16'd0;
  logic [1:0]  src_done;
  logic [1:0]  src_err;
  logic [1:0]  src_payload_req;
  logic [7:0]  src_dat0 = 8'h00;
  logic [7:0]  src_dat1 = 8'h00;
  logic        tx_en_pulse;
  logic [15:0] data_len;
  logic        payload_req_i = 1'b0;
  logic [7:0]  payload_dat_o;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [1:0]  grant;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] msg [5] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f};

  udp_tx_scheduler #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_125m        (clk_125m),
    .udp_gmii_rst_n  (udp_gmii_rst_n),
    .src_req         (src_req),
    .src_len0        (src_len0),
    .src_len1        (src_len1),
    .src_done        (src_done),
    .src_err         (src_err),
    .src_payload_req (src_payload_req),
    .src_dat0        (src_dat0),
    .src_dat1        (src_dat1),
    .tx_en_pulse     (tx_en_pulse),
    .data_len        (data_len),
    .payload_req_i   (payload_req_i),
    .payload_dat_o   (payload_dat_o),
    .tx_done         (tx_done),
    .busy            (busy),
    .grant           (grant)
  );

  always #4 clk_125m = ~clk_125m;
  always @(posedge clk_125m) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk_125m);
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int k = 0; k < 60; k++) begin
      if (tx_en_pulse === 1'b1) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) chk("start_wait", 0, 1);
  endtask

  initial begin
    int s;
    int p;
    int prev_p;
    int n;
    logic [1:0] exp_g;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_txen", tx_en_pulse, 0);
    chk("rst_len", data_len, 0);
    chk("rst_done", src_done, 0);
    chk("rst_err", src_err, 0);
    chk("rst_dat", payload_dat_o, 0);
    udp_gmii_rst_n = 1'b1;
    tick();

    // Single frame from source 0, payload mux
    src_len0 = 16'd29;
    src_req  = 2'b01;
    tick();
    chk("s0_txen", tx_en_pulse, 1);
    chk("s0_grant", grant, 2'b01);
    chk("s0_len", data_len, 29);
    chk("s0_busy", busy, 1);
    tick();
    chk("s0_txen_one", tx_en_pulse, 0);
    for (int i = 0; i < 5; i++) begin
      src_dat0 = msg[i];
      src_dat1 = 8'hA0 + 8'(i);
      payload_req_i = 1'b1;
      #1;
      chk("mux_dat", payload_dat_o, msg[i]);
      chk("mux_req", src_payload_req, 2'b01);
      payload_req_i = 1'b0;
      #1;
      chk("mux_req_off", src_payload_req, 2'b00);
      tick();
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    src_req = 2'b00;
    chk("s0_done", src_done, 2'b01);
    chk("s0_err", src_err, 2'b00);
    chk("s0_gnt_clr", grant, 2'b00);
    tick(); tick(); tick();
    chk("gap_busy", busy, 1);
    tick();
    chk("gap_idle", busy, 0);

    // tx_done in IDLE is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_txdone", src_done, 2'b00);
    chk("idle_txdone_busy", busy, 0);

    // Both request continuously: source 1 first since source 0 was last
    src_len0 = 16'd29;
    src_len1 = 16'd10;
    src_req  = 2'b11;
    exp_g    = 2'b10;
    prev_p   = -1;
    for (int f = 0; f < 4; f++) begin
      wait_start(s);
      chk("alt_grant", grant, exp_g);
      chk("alt_len", data_len, (exp_g == 2'b01) ? 29 : 10);
      if (prev_p >= 0) chk("alt_spacing", s, prev_p + 5);
      tick(); tick(); tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      prev_p = cyc;
      chk("alt_done", src_done, exp_g);
      exp_g = {exp_g[0], exp_g[1]};
    end
    src_req = 2'b00;
    repeat (6) tick();

    // Watchdog abort; request dropped mid-frame has no effect
    src_len0 = 16'd5;
    src_req  = 2'b01;
    wait_start(s);
    src_req = 2'b00;
    n = 0;
    while (src_done !== 2'b01 && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 101);
    chk("to_err", src_err, 2'b01);
    chk("to_grant", grant, 2'b00);
    src_req = 2'b01;
    wait_start(s);
    chk("after_to_grant", grant, 2'b01);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    src_req = 2'b00;
    chk("after_to_done", src_done, 2'b01);
    chk("after_to_err", src_err, 2'b00);
    repeat (6) tick();

    // Zero-length request from source 1
    src_len1 = 16'd0;
    src_req  = 2'b10;
    tick();
    src_req = 2'b00;
    chk("zl_done", src_done, 2'b10);
    chk("zl_err", src_err, 2'b10);
    chk("zl_txen", tx_en_pulse, 0);
    chk("zl_grant", grant, 2'b00);
    chk("zl_busy", busy, 1);
    tick();
    chk("zl_done_one", src_done, 2'b00);
    repeat (5) tick();

    // Reset mid-BUSY, then source 0 must win against source 1
    src_len0 = 16'd9;
    src_req  = 2'b01;
    wait_start(s);
    tick(); tick();
    udp_gmii_rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_len", data_len, 0);
    chk("mid_rst_txen", tx_en_pulse, 0);
    src_len1 = 16'd3;
    src_req  = 2'b11;
    tick();
    udp_gmii_rst_n = 1'b1;
    tick();
    chk("post_rst_txen", tx_en_pulse, 1);
    chk("post_rst_grant", grant, 2'b01);
    chk("post_rst_len", data_len, 9);
    src_req = 2'b10;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    src_req = 2'b00;
    chk("post_rst_done", src_done, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
